// File: rtl/logic_pkg.sv
// Shared types and constants for the registered bitwise logic unit.
package logic_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND   = 3'd0;
  localparam op_t OP_OR    = 3'd1;
  localparam op_t OP_NOTA  = 3'd2;
  localparam op_t OP_NAND  = 3'd3;
  localparam op_t OP_NOR   = 3'd4;
  localparam op_t OP_XOR   = 3'd5;
  localparam op_t OP_XNOR  = 3'd6;
  localparam op_t OP_PASSB = 3'd7;

endpackage

// File: rtl/logic_core.sv
// Combinational eight-function bitwise mux; no carry or sign handling.
module logic_core
  import logic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = b;
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_NOTA:  y = ~a;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XOR:   y = a ^ b;
      OP_XNOR:  y = ~(a ^ b);
      OP_PASSB: y = b;
      default:  y = b;
    endcase
  end

endmodule

// File: rtl/logic_pipe.sv
// Registered bitwise logic unit with valid/ready handshake, a chaining
// accumulator and a saturating count of accepted beats.
module logic_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_src_acc,
  input  logic             in_acc_we,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] beat_cnt
);

  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] y;

  // The only combinational path from out_ready.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // Reads the accumulator before any clear or write lands this edge.
  assign b_eff    = in_src_acc ? acc : in_b;

  logic_core #(.WIDTH(WIDTH)) u_core (
    .op (in_op),
    .a  (in_a),
    .b  (b_eff),
    .y  (y)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_zero  <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_y     <= y;
      out_zero  <= (y == '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A write from an accepted beat takes priority over a clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc <= '0;
    end else if (accept && in_acc_we) begin
      acc <= y;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_cnt <= '0;
    end else if (accept && (beat_cnt != {CNT_W{1'b1}})) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_pipe.sv
// Scoreboard bench for logic_pipe: directed beats push expected results,
// a monitor pops and compares on every output handshake.
module tb_logic_pipe;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_src_acc = 1'b0;
  logic        in_acc_we = 1'b0;
  logic        acc_clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_y;
  logic        out_zero;
  logic [31:0] acc;
  logic [15:0] beat_cnt;

  // CNT_W=2 instance for saturation
  logic        s_valid = 1'b0;
  logic        s_in_ready, s_out_valid, s_out_zero;
  logic [31:0] s_out_y, s_acc;
  logic [1:0]  s_cnt;
  logic        one = 1'b1;
  logic        zero = 1'b0;

  // WIDTH=8 instance
  logic        w_valid = 1'b0;
  logic [7:0]  w_a = '0;
  logic [7:0]  w_b = '0;
  logic        w_in_ready, w_out_valid, w_out_zero;
  logic [7:0]  w_out_y, w_acc;
  logic [15:0] w_cnt;

  int compared = 0;
  int mismatched = 0;
  int n_beats = 0;
  int n_txn = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  logic_pipe #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_src_acc(in_src_acc),
    .in_acc_we(in_acc_we), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero), .acc(acc),
    .beat_cnt(beat_cnt)
  );

  logic_pipe #(.WIDTH(32), .CNT_W(2)) u_sat (
    .clk(clk), .resetn(resetn), .in_valid(s_valid), .in_ready(s_in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_src_acc(zero),
    .in_acc_we(zero), .acc_clr(zero), .out_valid(s_out_valid),
    .out_ready(one), .out_y(s_out_y), .out_zero(s_out_zero), .acc(s_acc),
    .beat_cnt(s_cnt)
  );

  logic_pipe #(.WIDTH(8), .CNT_W(16)) u_w8 (
    .clk(clk), .resetn(resetn), .in_valid(w_valid), .in_ready(w_in_ready),
    .in_op(in_op), .in_a(w_a), .in_b(w_b), .in_src_acc(zero),
    .in_acc_we(zero), .acc_clr(zero), .out_valid(w_out_valid),
    .out_ready(one), .out_y(w_out_y), .out_zero(w_out_zero), .acc(w_acc),
    .beat_cnt(w_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Offer one beat; push its expected result once it is seen to be accepted.
  task automatic beat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic src, input logic we, input logic [31:0] exp);
    bit ok = 0;
    in_op = op; in_a = a; in_b = b; in_src_acc = src; in_acc_we = we;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL beat_accept_timeout: got in_ready 0 expected 1");
    end else begin
      sb.push_back(exp);
      n_beats++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_src_acc = 1'b0; in_acc_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: one compare per output handshake.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (resetn && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_output: got 0x%08h expected none", out_y);
        end else begin
          e = sb.pop_front();
          n_txn++;
          $display("txn %0d: out_y=0x%08h zero=%0b expect 0x%08h", n_txn, out_y, out_zero, e);
          check("out_y", out_y, e);
          check("out_zero", {31'd0, out_zero}, {31'd0, (e == 32'd0)});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_y", out_y, 32'd0);
    check("rst_out_zero", {31'd0, out_zero}, 32'd1);
    check("rst_acc", acc, 32'd0);
    check("rst_beat_cnt", {16'd0, beat_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    resetn = 1'b1;
    idle(1);

    // WIDTH=8 NAND
    in_op = 3'd3; w_a = 8'hAA; w_b = 8'hCC; w_valid = 1'b1;
    idle(1);
    w_valid = 1'b0;
    check("w8_nand_y", {24'd0, w_out_y}, 32'h77);
    check("w8_valid", {31'd0, w_out_valid}, 32'd1);

    // CNT_W=2 saturation
    begin
      logic [1:0] exp_cnt [5];
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      s_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
        idle(1);
        check($sformatf("sat_cnt_%0d", i), {30'd0, s_cnt}, {30'd0, exp_cnt[i]});
      end
      s_valid = 1'b0;
    end

    // Op sweep, back-to-back
    beat(3'd0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 0, 32'h00F0_000F);
    beat(3'd1, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 0, 32'hFFF0_0FFF);
    beat(3'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 0, 32'h0F0F_FF00);
    beat(3'd3, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 0, 32'hFF0F_FFF0);
    beat(3'd4, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 0, 32'h000F_F000);
    beat(3'd5, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 0, 32'hFF00_0FF0);
    beat(3'd6, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 0, 32'h00FF_F00F);
    beat(3'd7, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 0, 32'h0FF0_0F0F);

    // Zero flag
    beat(3'd0, 32'hFFFF_FFFF, 32'h0, 0, 0, 32'h0);
    beat(3'd1, 32'hFFFF_FFFF, 32'h0, 0, 0, 32'hFFFF_FFFF);
    idle(2);
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure
    out_ready = 1'b0;
    beat(3'd5, 32'hAAAA_0000, 32'h0000_5555, 0, 0, 32'hAAAA_5555);
    in_op = 3'd7; in_a = 32'h0; in_b = 32'h1111_2222; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_y", out_y, 32'hAAAA_5555);
      check("bp_beat_cnt", {16'd0, beat_cnt}, n_beats);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    beat(3'd7, 32'h0, 32'h1111_2222, 0, 0, 32'h1111_2222);
    check("fill_drain_valid", {31'd0, out_valid}, 32'd1);
    beat(3'd1, 32'h3300_0000, 32'h0000_0033, 0, 0, 32'h3300_0033);

    // Accumulator chain, zero bubble
    beat(3'd5, 32'h1, 32'h0, 0, 1, 32'h1);
    check("chain_acc_1", acc, 32'h1);
    beat(3'd5, 32'h2, 32'h0, 1, 1, 32'h3);
    check("chain_acc_3", acc, 32'h3);
    acc_clr = 1'b1;
    idle(1);
    acc_clr = 1'b0;
    check("clr_acc", acc, 32'h0);
    acc_clr = 1'b1;
    beat(3'd7, 32'h0, 32'h5, 0, 1, 32'h5);
    acc_clr = 1'b0;
    check("clr_vs_write_acc", acc, 32'h5);
    acc_clr = 1'b1;
    beat(3'd5, 32'h0, 32'h0, 1, 0, 32'h5);
    acc_clr = 1'b0;
    check("preclear_read_acc", acc, 32'h0);
    check("beat_cnt_total", {16'd0, beat_cnt}, n_beats);

    // Reset mid-operation discards held result
    idle(2);
    out_ready = 1'b0;
    beat(3'd1, 32'h1234, 32'h0, 0, 1, 32'h1234);
    check("pre_rst_acc", acc, 32'h1234);
    resetn = 1'b0;
    #1;
    sb.delete();
    n_beats = 0;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_y", out_y, 32'd0);
    check("mid_rst_out_zero", {31'd0, out_zero}, 32'd1);
    check("mid_rst_acc", acc, 32'd0);
    check("mid_rst_beat_cnt", {16'd0, beat_cnt}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    out_ready = 1'b1;
    idle(3);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
